// File: rtl/pa_clic_arb.sv
// CLIC interrupt arbiter: picks the highest-intctl eligible kid through a two-stage
// registered tree, presents it to the core, and returns a one-cycle claim on ack.
module pa_clic_arb #(
    parameter int KID_NUM = 64,
    parameter int CTLBITS = 3,
    parameter int ID_W    = 6,
    parameter int GRP_NUM = 8
) (
    input  logic                             clic_clk,
    input  logic                             cpurst_b,
    input  logic [KID_NUM-1:0]               kid_arb_int_req,
    input  logic [KID_NUM*(CTLBITS+1)-1:0]   kid_arb_int_all,
    input  logic [KID_NUM-1:0]               kid_arb_int_hv,
    input  logic [CTLBITS-1:0]               clic_mintthresh,
    input  logic                             cpu_arb_int_ack,
    output logic                             arb_cpu_int_vld,
    output logic [ID_W-1:0]                  arb_cpu_int_id,
    output logic [CTLBITS-1:0]               arb_cpu_int_lvl,
    output logic                             arb_cpu_int_hv,
    output logic [KID_NUM-1:0]               arb_kid_int_claim
);

    localparam int GRPS  = KID_NUM / GRP_NUM;
    localparam int LID_W = $clog2(GRP_NUM);
    localparam int GID_W = ID_W - LID_W;

    typedef enum logic [1:0] {ARB, CLAIM, FLUSH0, FLUSH1} state_e;

    logic [GRPS-1:0]    grp_vld_d, grp_vld_q;
    logic [GRPS-1:0]    grp_hv_d, grp_hv_q;
    logic [CTLBITS-1:0] grp_ctl_d [GRPS];
    logic [CTLBITS-1:0] grp_ctl_q [GRPS];
    logic [LID_W-1:0]   grp_lid_d [GRPS];
    logic [LID_W-1:0]   grp_lid_q [GRPS];

    logic               win_vld_d, win_vld_q;
    logic [CTLBITS-1:0] win_ctl_d, win_ctl_q;
    logic [ID_W-1:0]    win_id_d, win_id_q;
    logic               win_hv_d, win_hv_q;

    state_e             state_d, state_q;
    logic [KID_NUM-1:0] claim_d, claim_q;

    // Strict greater-than while scanning upward keeps the lower index on ties.
    always_comb begin
        logic               found;
        logic [CTLBITS-1:0] best;
        logic [CTLBITS-1:0] ctl;
        for (int g = 0; g < GRPS; g++) begin
            found        = 1'b0;
            best         = '0;
            grp_lid_d[g] = '0;
            grp_hv_d[g]  = 1'b0;
            for (int i = 0; i < GRP_NUM; i++) begin
                ctl = kid_arb_int_all[(g*GRP_NUM+i)*(CTLBITS+1) +: CTLBITS];
                if (kid_arb_int_req[g*GRP_NUM+i] &&
                    kid_arb_int_all[(g*GRP_NUM+i)*(CTLBITS+1)+CTLBITS] &&
                    (!found || ctl > best)) begin
                    found        = 1'b1;
                    best         = ctl;
                    grp_lid_d[g] = LID_W'(i);
                    grp_hv_d[g]  = kid_arb_int_hv[g*GRP_NUM+i];
                end
            end
            grp_vld_d[g] = found;
            grp_ctl_d[g] = best;
        end
    end

    always_comb begin
        logic found;
        found     = 1'b0;
        win_ctl_d = '0;
        win_id_d  = '0;
        win_hv_d  = 1'b0;
        for (int g = 0; g < GRPS; g++) begin
            if (grp_vld_q[g] && (!found || grp_ctl_q[g] > win_ctl_d)) begin
                found     = 1'b1;
                win_ctl_d = grp_ctl_q[g];
                win_id_d  = {GID_W'(g), grp_lid_q[g]};
                win_hv_d  = grp_hv_q[g];
            end
        end
        win_vld_d = found && (win_ctl_d > clic_mintthresh);
    end

    always_comb begin
        state_d = state_q;
        claim_d = '0;
        case (state_q)
            ARB: begin
                if (cpu_arb_int_ack && arb_cpu_int_vld) begin
                    state_d = CLAIM;
                    claim_d = KID_NUM'(1) << win_id_q;
                end
            end
            CLAIM:   state_d = FLUSH0;
            FLUSH0:  state_d = FLUSH1;
            FLUSH1:  state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clic_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            grp_vld_q <= '0;
            grp_hv_q  <= '0;
            for (int g = 0; g < GRPS; g++) begin
                grp_ctl_q[g] <= '0;
                grp_lid_q[g] <= '0;
            end
            win_vld_q <= 1'b0;
            win_ctl_q <= '0;
            win_id_q  <= '0;
            win_hv_q  <= 1'b0;
            state_q   <= ARB;
            claim_q   <= '0;
        end else begin
            grp_vld_q <= grp_vld_d;
            grp_hv_q  <= grp_hv_d;
            for (int g = 0; g < GRPS; g++) begin
                grp_ctl_q[g] <= grp_ctl_d[g];
                grp_lid_q[g] <= grp_lid_d[g];
            end
            win_vld_q <= win_vld_d;
            win_ctl_q <= win_ctl_d;
            win_id_q  <= win_id_d;
            win_hv_q  <= win_hv_d;
            state_q   <= state_d;
            claim_q   <= claim_d;
        end
    end

    assign arb_cpu_int_vld   = win_vld_q & (state_q == ARB);
    assign arb_cpu_int_id    = win_id_q;
    assign arb_cpu_int_lvl   = win_ctl_q;
    assign arb_cpu_int_hv    = win_hv_q;
    assign arb_kid_int_claim = claim_q;

endmodule

// File: tb/tb_pa_clic_arb.sv
// Directed bench for pa_clic_arb: arbitration, threshold, claim/flush sequencing
// and asynchronous reset, all against hand-computed expectations.
module tb_pa_clic_arb;

    logic          clk;
    logic          rstN;
    logic [63:0]   kidReq;
    logic [255:0]  kidAll;
    logic [63:0]   kidHv;
    logic [2:0]    thresh;
    logic          ack;
    logic          vld;
    logic [5:0]    id;
    logic [2:0]    lvl;
    logic          hv;
    logic [63:0]   claim;

    int checkCount = 0;
    int errorCount = 0;

    pa_clic_arb dut (
        .clic_clk          (clk),
        .cpurst_b          (rstN),
        .kid_arb_int_req   (kidReq),
        .kid_arb_int_all   (kidAll),
        .kid_arb_int_hv    (kidHv),
        .clic_mintthresh   (thresh),
        .cpu_arb_int_ack   (ack),
        .arb_cpu_int_vld   (vld),
        .arb_cpu_int_id    (id),
        .arb_cpu_int_lvl   (lvl),
        .arb_cpu_int_hv    (hv),
        .arb_kid_int_claim (claim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int k, input logic r, input logic v,
                                 input logic [2:0] c, input logic h);
        kidReq[k]       = r;
        kidAll[k*4 +: 4] = {v, c};
        kidHv[k]        = h;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " vld"}, 64'(vld), 64'd0);
        checkOutput({tag, " id"}, 64'(id), 64'd0);
        checkOutput({tag, " lvl"}, 64'(lvl), 64'd0);
        checkOutput({tag, " hv"}, 64'(hv), 64'd0);
        checkOutput({tag, " claim"}, claim, 64'd0);
    endtask

    initial begin
        kidReq = '0;
        kidAll = '0;
        kidHv  = '0;
        thresh = 3'd0;
        ack    = 1'b0;
        rstN   = 1'b0;
        repeat (3) tick();
        checkAllZero("reset");
        rstN = 1'b1;
        tick();

        // Single kid, two-cycle latency, hv propagated
        applyStimulus(5, 1'b1, 1'b1, 3'd3, 1'b1);
        tick();
        checkOutput("t1 early vld", 64'(vld), 64'd0);
        tick();
        checkOutput("t1 vld", 64'(vld), 64'd1);
        checkOutput("t1 id", 64'(id), 64'd5);
        checkOutput("t1 lvl", 64'(lvl), 64'd3);
        checkOutput("t1 hv", 64'(hv), 64'd1);
        applyStimulus(5, 1'b0, 1'b0, 3'd0, 1'b0);

        // Tie across groups goes to lower index, then higher ctl overtakes
        applyStimulus(9, 1'b1, 1'b1, 3'd6, 1'b0);
        applyStimulus(40, 1'b1, 1'b1, 3'd6, 1'b0);
        tick(); tick();
        checkOutput("t2 tie id", 64'(id), 64'd9);
        checkOutput("t2 tie lvl", 64'(lvl), 64'd6);
        checkOutput("t2 tie hv", 64'(hv), 64'd0);
        applyStimulus(40, 1'b1, 1'b1, 3'd7, 1'b0);
        tick();
        checkOutput("t2 raise early id", 64'(id), 64'd9);
        tick();
        checkOutput("t2 raise id", 64'(id), 64'd40);
        checkOutput("t2 raise lvl", 64'(lvl), 64'd7);
        applyStimulus(9, 1'b0, 1'b0, 3'd0, 1'b0);
        applyStimulus(40, 1'b0, 1'b0, 3'd0, 1'b0);

        // Index extremes tie; then request without valid bit is not eligible
        applyStimulus(0, 1'b1, 1'b1, 3'd7, 1'b0);
        applyStimulus(63, 1'b1, 1'b1, 3'd7, 1'b1);
        tick(); tick();
        checkOutput("edge tie id", 64'(id), 64'd0);
        applyStimulus(0, 1'b0, 1'b0, 3'd0, 1'b0);
        applyStimulus(20, 1'b1, 1'b0, 3'd7, 1'b0);
        tick(); tick();
        checkOutput("novalid id", 64'(id), 64'd63);
        checkOutput("novalid hv", 64'(hv), 64'd1);
        applyStimulus(63, 1'b0, 1'b0, 3'd0, 1'b0);
        applyStimulus(20, 1'b0, 1'b0, 3'd0, 1'b0);

        // Threshold: equal blocks, lower admits
        applyStimulus(12, 1'b1, 1'b1, 3'd2, 1'b0);
        thresh = 3'd2;
        tick(); tick();
        checkOutput("t3 eq thresh vld", 64'(vld), 64'd0);
        tick();
        checkOutput("t3 eq thresh vld2", 64'(vld), 64'd0);
        thresh = 3'd1;
        tick(); tick();
        checkOutput("t3 vld", 64'(vld), 64'd1);
        checkOutput("t3 id", 64'(id), 64'd12);

        // Ack, claim, flush; ack held high through claim/flush and into idle ARB
        ack = 1'b1;
        tick();
        checkOutput("t4 claim", claim, 64'd1 << 12);
        checkOutput("t4 claim vld", 64'(vld), 64'd0);
        tick();
        checkOutput("t4 flush0 claim", claim, 64'd0);
        checkOutput("t4 flush0 vld", 64'(vld), 64'd0);
        applyStimulus(12, 1'b0, 1'b0, 3'd0, 1'b0);
        tick();
        checkOutput("t4 flush1 claim", claim, 64'd0);
        checkOutput("t4 flush1 vld", 64'(vld), 64'd0);
        tick();
        checkOutput("t4 arb vld", 64'(vld), 64'd0);
        checkOutput("t4 arb claim", claim, 64'd0);
        tick();
        checkOutput("t5 ack novld claim", claim, 64'd0);
        ack = 1'b0;
        applyStimulus(3, 1'b1, 1'b1, 3'd5, 1'b0);
        tick();
        checkOutput("t4 kid3 early vld", 64'(vld), 64'd0);
        tick();
        checkOutput("t4 kid3 vld", 64'(vld), 64'd1);
        checkOutput("t4 kid3 id", 64'(id), 64'd3);
        checkOutput("t4 kid3 lvl", 64'(lvl), 64'd5);

        // Reset asserted in FLUSH0 clears everything immediately
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checkOutput("t6 claim", claim, 64'd1 << 3);
        tick();
        rstN = 1'b0;
        #1;
        checkAllZero("t6 rst");
        tick();
        rstN = 1'b1;
        tick();
        checkOutput("t6 resume early vld", 64'(vld), 64'd0);
        tick();
        checkOutput("t6 resume vld", 64'(vld), 64'd1);
        checkOutput("t6 resume id", 64'(id), 64'd3);

        // All-dummy kids never produce a winner
        kidReq = '0;
        kidAll = '0;
        kidHv  = '0;
        thresh = 3'd0;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            ack = i[0];
            tick();
            checkOutput("dummy vld", 64'(vld), 64'd0);
            checkOutput("dummy claim", claim, 64'd0);
        end
        ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
